dqpsk_frame_ctrl: RTL and testbench
===================================

Name: dqpsk_frame_ctrl

Overview:
Frame scheduler for the DQPSK transmit code-transform stage (serial-to-parallel, differential encoder, bipolar mapping).
- Sequences each burst: re-aligns and resets the encoder, then emits a serial bit stream at the bit rate in order preamble -> sync word -> payload bytes -> tail zeros.
- Pulls payload bytes from an upstream byte source via a valid/ready handshake.
- Sits between the frame/data source and the encoder input `din`, in the 8 MHz system clock domain.

Parameters:
- CLKS_PER_BIT, 4, system clocks per serial bit (8 MHz clk / 2 Mbps); must be >= 2.
- PRE_BITS, 32, preamble length in bits (alternating 1,0,1,0...; first bit 1); range 2..255.
- SYNC_WORD, 16'hE5B1, sync pattern; sent MSB first.
- TAIL_BITS, 8, trailing zero bits that flush the encoder; range 1..255.

Ports:
- clk, input, 1, system clock, 8 MHz.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, frame request; sampled only in IDLE.
- frame_len, input, 8, payload length in bytes; sampled with start; 0 is illegal.
- byte_data, input, 8, payload byte; sent MSB first.
- byte_valid, input, 1, byte_data valid.
- byte_ready, output, 1, one-cycle byte-fetch strobe; a transfer occurs when byte_valid && byte_ready.
- din, output, 1, serial bit to encoder, registered.
- enc_rst, output, 1, active-high encoder reset pulse.
- tx_en, output, 1, high while any frame bit is on din.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse at end of frame.
- underrun, output, 1, sticky flag; cleared on an accepted start.

Behaviour:
Reset (rst low, asynchronous):
- State IDLE; all counters 0.
- din=0, enc_rst=0, tx_en=0, busy=0, done=0, byte_ready=0, underrun=0.

State machine: IDLE -> ALIGN -> PRE -> SYNC -> PAY -> TAIL -> IDLE.
- IDLE: start=1 with frame_len!=0 latches frame_len, clears underrun, enters ALIGN. start with frame_len=0 is ignored: stay IDLE, no outputs change. start in any other state is ignored.
- ALIGN: exactly 2 cycles.
  - Cycle 1: enc_rst=1.
  - Cycle 2: enc_rst=0; din is loaded with the first preamble bit (1); bit-phase counter ph is cleared.
  - Next cycle: ph=0 of bit 0, tx_en=1.
- Bit timing:
  - ph counts 0..CLKS_PER_BIT-1 and wraps.
  - Each bit is held on din for exactly CLKS_PER_BIT cycles, starting at ph=0.
  - din and the state change only on the ph wrap edge.
  - Result: the encoder's count==0 / count==4 sample points fall at ph=0 of successive bits.
- PRE: PRE_BITS bits of 1,0,1,0,...
- SYNC: 16 bits of SYNC_WORD, MSB first.
- PAY:
  - frame_len*8 bits, each byte MSB first.
  - byte_ready pulses at ph=CLKS_PER_BIT-2 of the last bit of the previous field or byte.
  - If byte_valid=1 in the strobe cycle, byte_data loads the shift register at the wrap.
  - If byte_valid=0: underrun<=1, byte 8'h00 is substituted, and the frame continues. Frame timing never stalls.
- TAIL: TAIL_BITS zeros.
  - On the wrap of the last tail bit: din=0, tx_en=0, done=1 for 1 cycle, state returns to IDLE; busy falls in the same cycle.
- Frame length in clocks, start to done, = 2 + CLKS_PER_BIT*(PRE_BITS+16+8*frame_len+TAIL_BITS).
- Reset mid-frame: immediate abort to IDLE with reset values. No done pulse; the encoder is re-reset by the next ALIGN.
- byte_valid while byte_ready=0 is ignored; nothing is consumed.

Optional Feature:
DQPSK_SCRAMBLER_EN
- Defined:
  - Payload bits only are XORed with an additive scrambler, polynomial x^7+x^4+1.
  - 7-bit LFSR seeded to 7'h7F in ALIGN and advanced once per payload bit.
  - Output bit = lfsr[6]^lfsr[3]; that same bit is shifted into lfsr[0].
  - Preamble, sync and tail are unscrambled.
- Undefined: payload bits pass unmodified; no LFSR logic is synthesised.

Test Plan:
1. Reset: rst=0 mid-PAY -> all outputs 0 within the same cycle; IDLE after release; start then runs a clean frame.
2. Basic frame (defaults, frame_len=2, bytes 8'hA5, 8'h3C, valid always high):
   - din per bit = 32 alternating bits starting at 1, then E5B1 MSB-first, then A5, 3C, then 8 zeros.
   - Each bit lasts exactly 4 clocks.
   - done arrives exactly 2+4*(32+16+16+8)=290 clocks after start; 2 byte_ready handshakes.
3. Alignment: enc_rst high exactly 1 cycle, 2 cycles before the first preamble bit; ph=0 of every bit lines up with an encoder count of 0 or 4.
4. Underrun: frame_len=3, byte_valid low at the second strobe -> second byte sent as 00, underrun=1 until the next start, total frame length unchanged.
5. Illegal or ignored start: frame_len=0 -> busy stays 0. start pulsed during SYNC -> no effect on the current frame.
6. Scrambler (macro defined): frame_len=1, byte 8'h00 -> payload bits equal the first 8 LFSR outputs from seed 7'h7F; preamble and sync unchanged.

Source files
------------

// File: rtl/dqpsk_frame_ctrl_if.sv
// dqpsk_frame_ctrl_if: payload byte source handshake (valid / one-cycle ready strobe).
interface dqpsk_frame_ctrl_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    modport master (output byte_data, byte_valid, input byte_ready);
    modport slave  (input byte_data, byte_valid, output byte_ready);
endinterface

// File: rtl/dqpsk_frame_ctrl.sv
// dqpsk_frame_ctrl: DQPSK burst scheduler emitting preamble, sync, payload and tail bits to the encoder.
// Optional payload scrambler (x^7+x^4+1) enabled by defining DQPSK_SCRAMBLER_EN.
module dqpsk_frame_ctrl #(
    parameter int          CLKS_PER_BIT = 4,
    parameter int          PRE_BITS     = 32,
    parameter logic [15:0] SYNC_WORD    = 16'hE5B1,
    parameter int          TAIL_BITS    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         frame_len,
    dqpsk_frame_ctrl_if.slave  bus,
    output logic               din,
    output logic               enc_rst,
    output logic               tx_en,
    output logic               busy,
    output logic               done,
    output logic               underrun
);
    localparam int PW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    typedef enum logic [2:0] {IDLE, ALIGN, PRE, SYNC, PAY, TAIL} state_t;
    state_t        st;
    logic [PW-1:0] ph;
    logic [7:0]    bc, nb, len, buf_q, sr;
    logic          al, wrap, last_byte, fetch, pay_adv, pay_raw, pay_bit;
    assign wrap      = ph == PW'(CLKS_PER_BIT - 1);
    assign last_byte = nb == len - 8'd1;
    assign fetch     = (st == SYNC && bc == 8'd15) || (st == PAY && bc == 8'd7 && !last_byte);
    assign bus.byte_ready = fetch && ph == PW'(CLKS_PER_BIT - 2);
    // Every payload bit that is loaded onto din, including the first one leaving SYNC.
    assign pay_adv   = wrap && ((st == SYNC && bc == 8'd15) || (st == PAY && !(bc == 8'd7 && last_byte)));
    assign pay_raw   = (st == SYNC || bc == 8'd7) ? buf_q[7] : sr[6];
`ifdef DQPSK_SCRAMBLER_EN
    logic [6:0] lfsr;
    logic       sbit;
    assign sbit    = lfsr[6] ^ lfsr[3];
    assign pay_bit = pay_raw ^ sbit;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= '0;
        else if (st == ALIGN) lfsr <= 7'h7F;
        else if (pay_adv) lfsr <= {lfsr[5:0], sbit};
    end
`else
    assign pay_bit = pay_raw;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st       <= IDLE;
            ph       <= '0;
            bc       <= '0;
            nb       <= '0;
            len      <= '0;
            buf_q    <= '0;
            sr       <= '0;
            al       <= 1'b0;
            din      <= 1'b0;
            enc_rst  <= 1'b0;
            tx_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.byte_ready) begin
                buf_q <= bus.byte_valid ? bus.byte_data : 8'h00;
                if (!bus.byte_valid) underrun <= 1'b1;
            end
            case (st)
                IDLE: if (start && frame_len != 8'd0) begin
                    st       <= ALIGN;
                    len      <= frame_len;
                    underrun <= 1'b0;
                    enc_rst  <= 1'b1;
                    busy     <= 1'b1;
                    al       <= 1'b0;
                end
                ALIGN: begin
                    enc_rst <= 1'b0;
                    al      <= 1'b1;
                    if (al) begin
                        st    <= PRE;
                        din   <= 1'b1;
                        tx_en <= 1'b1;
                        ph    <= '0;
                        bc    <= '0;
                        nb    <= '0;
                    end
                end
                default: begin
                    ph <= wrap ? '0 : ph + 1'b1;
                    if (wrap) begin
                        bc <= bc + 8'd1;
                        case (st)
                            PRE: if (bc == 8'(PRE_BITS - 1)) begin
                                st  <= SYNC;
                                bc  <= '0;
                                din <= SYNC_WORD[15];
                            end else din <= ~din;
                            SYNC: if (bc == 8'd15) begin
                                st  <= PAY;
                                bc  <= '0;
                                sr  <= buf_q;
                                din <= pay_bit;
                            end else din <= SYNC_WORD[4'd14 - bc[3:0]];
                            PAY: if (bc == 8'd7) begin
                                bc <= '0;
                                nb <= nb + 8'd1;
                                if (last_byte) begin
                                    st  <= TAIL;
                                    din <= 1'b0;
                                end else begin
                                    sr  <= buf_q;
                                    din <= pay_bit;
                                end
                            end else begin
                                sr  <= sr << 1;
                                din <= pay_bit;
                            end
                            TAIL: begin
                                din <= 1'b0;
                                if (bc == 8'(TAIL_BITS - 1)) begin
                                    st    <= IDLE;
                                    bc    <= '0;
                                    tx_en <= 1'b0;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end
                            default: st <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dqpsk_frame_ctrl.sv
// tb_dqpsk_frame_ctrl: directed frames checked bit-by-bit against a bench-built expected stream.
module tb_dqpsk_frame_ctrl;
    logic       clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [7:0] frame_len = 8'd0;
    logic       din, enc_rst, tx_en, busy, done, underrun;
    int         checks = 0, failures = 0;
    dqpsk_frame_ctrl_if bus();
    dqpsk_frame_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .bus(bus.slave),
        .din(din), .enc_rst(enc_rst), .tx_en(tx_en), .busy(busy), .done(done), .underrun(underrun)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // Runs one frame; bytes[8k+:8] is byte k, vmask[k] is byte_valid at strobe k.
    task automatic run_frame(input int n, input logic [23:0] bytes, input logic [2:0] vmask,
                             input bit poke, input logic exp_under);
        logic        exp_bits[$];
        logic [15:0] sw = 16'hE5B1;
        logic [7:0]  b;
        logic        eb, exp_en, exp_rdy;
        int          nbits, u, bad, nfetch, bi;
`ifdef DQPSK_SCRAMBLER_EN
        logic [6:0]  l = 7'h7F;
        logic        s;
`endif
        for (int i = 0; i < 32; i++) exp_bits.push_back(i % 2 == 0);
        for (int i = 15; i >= 0; i--) exp_bits.push_back(sw[i]);
        for (int k = 0; k < n; k++) begin
            b = vmask[k] ? bytes[8*k +: 8] : 8'h00;
            for (int j = 7; j >= 0; j--) begin
                eb = b[j];
`ifdef DQPSK_SCRAMBLER_EN
                s = l[6] ^ l[3];
                eb = eb ^ s;
                l = {l[5:0], s};
`endif
                exp_bits.push_back(eb);
            end
        end
        for (int i = 0; i < 8; i++) exp_bits.push_back(1'b0);
        nbits = exp_bits.size();
        bad = 0;
        nfetch = 0;
        u = -1;
        @(posedge clk); #1;
        start = 1'b1;
        frame_len = 8'(n);
        while (u < 4 * nbits + 12) begin
            @(posedge clk); #1;
            u++;
            if (u == 0) start = 1'b0;
            if (poke && u == 2 + 4 * 40) begin start = 1'b1; frame_len = 8'd9; end
            if (poke && u == 3 + 4 * 40) start = 1'b0;
            bi = (u - 2) / 4;
            exp_en = u >= 2 && bi < nbits;
            exp_rdy = exp_en && (u - 2) % 4 == 2 && bi >= 47 && (bi - 47) % 8 == 0 && bi <= 47 + 8 * (n - 1);
            if (din !== (exp_en ? exp_bits[bi] : 1'b0) || tx_en !== exp_en || enc_rst !== (u == 0)
                || busy !== (u < 2 + 4 * nbits) || bus.byte_ready !== exp_rdy) bad++;
            if (bus.byte_ready) begin
                bus.byte_data = bytes[8*nfetch +: 8];
                bus.byte_valid = vmask[nfetch];
                nfetch++;
            end
            if (done) break;
        end
        chk("done_latency", u, 2 + 4 * nbits);
        chk("frame_cycles", bad, 0);
        chk("fetch_count", nfetch, n);
        chk("underrun_end", underrun, exp_under);
        @(posedge clk); #1;
        chk("done_pulse_width", done, 1'b0);
    endtask
    initial begin
        bus.byte_data = 8'h00;
        bus.byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_din", din, 1'b0);
        chk("rst_enc_rst", enc_rst, 1'b0);
        chk("rst_tx_en", tx_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_byte_ready", bus.byte_ready, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        rst = 1'b1;
        run_frame(2, {8'h00, 8'h3C, 8'hA5}, 3'b111, 1'b0, 1'b0);
        @(posedge clk); #1;
        start = 1'b1;
        frame_len = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("len0_busy", busy, 1'b0);
        @(posedge clk); #1;
        chk("len0_busy_later", busy, 1'b0);
        chk("len0_enc_rst", enc_rst, 1'b0);
        run_frame(3, {8'h81, 8'h77, 8'h5A}, 3'b101, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("underrun_sticky", underrun, 1'b1);
        run_frame(2, {8'h00, 8'h0F, 8'hF0}, 3'b111, 1'b1, 1'b0);
        @(posedge clk); #1;
        start = 1'b1;
        frame_len = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2 + 4 * 52) @(posedge clk);
        #1;
        chk("pay_busy_before_rst", busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_tx_en", tx_en, 1'b0);
        chk("async_rst_din", din, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_done", done, 1'b0);
        run_frame(1, {8'h00, 8'h00, 8'h00}, 3'b111, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
